// File: rtl/data_mem_responder.sv
// Data-memory target for a single-cycle core: word RAM below IO_BASE plus a small
// memory-mapped I/O window (TX FIFO, free-running cycle counter, drop counter).
module data_mem_responder #(
   parameter int unsigned MEM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address_to_mem,
   input  logic [31:0] data_to_mem,
   input  logic        WE,
   output logic [31:0] data_from_mem,
   output logic        out_valid,
   output logic [31:0] out_data,
   input  logic        out_ready
);

   localparam int unsigned AW        = $clog2(MEM_WORDS);
   localparam int unsigned PW        = $clog2(FIFO_DEPTH);
   localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
   localparam logic [29:0] IO_WORD   = IO_BASE[31:2];
   localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(FIFO_DEPTH);

   logic [31:0]   ram  [MEM_WORDS];
   logic [31:0]   fifo [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic [31:0]   cycle;
   logic [15:0]   drops;
   logic [7:0]    count8;

   logic ram_hit, tx_hit, status_hit, cycle_hit, drops_hit;
   logic full, empty, push, pop, push_ok, drop;

   // The full-width compare also keeps addr[1:0] in use; they never affect decode otherwise.
   assign ram_hit    = address_to_mem < RAM_BYTES;
   assign tx_hit     = address_to_mem[31:2] == IO_WORD;
   assign status_hit = address_to_mem[31:2] == IO_WORD + 30'd1;
   assign cycle_hit  = address_to_mem[31:2] == IO_WORD + 30'd2;
   assign drops_hit  = address_to_mem[31:2] == IO_WORD + 30'd3;

   assign full      = count == DEPTH_CNT;
   assign empty     = count == '0;
   assign out_valid = !empty;
   assign out_data  = empty ? '0 : fifo[rd_ptr];
   assign count8    = 8'(count);

   assign push    = WE & tx_hit;
   assign pop     = out_valid & out_ready;
   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign push_ok = push & (!full | pop);
   assign drop    = push & full & !pop;

   always_comb begin
      data_from_mem = '0;
      if (ram_hit)
         data_from_mem = ram[address_to_mem[AW+1:2]];
      else if (status_hit)
         data_from_mem = {16'b0, count8, 6'b0, full, empty};
      else if (cycle_hit)
         data_from_mem = cycle;
      else if (drops_hit)
         data_from_mem = {16'b0, drops};
   end

   always_ff @(posedge clk) begin
      if (WE && ram_hit)
         ram[address_to_mem[AW+1:2]] <= data_to_mem;
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo[wr_ptr] <= data_to_mem;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         cycle  <= '0;
         drops  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: ;
         endcase

         if (WE && cycle_hit)
            cycle <= data_to_mem;
         else
            cycle <= cycle + 32'd1;

         // A clearing write takes priority over a drop in the same cycle.
         if (WE && drops_hit)
            drops <= '0;
         else if (drop && drops != '1)
            drops <= drops + 16'd1;
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: RAM decode, FIFO order and
// overflow, cycle counter load/wrap, async reset, and randomised backpressure.
module tb_data_mem_responder;

   localparam logic [31:0] TXDATA = 32'h0000_8000;
   localparam logic [31:0] STATUS = 32'h0000_8004;
   localparam logic [31:0] CYCLE  = 32'h0000_8008;
   localparam logic [31:0] DROPS  = 32'h0000_800C;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] address_to_mem;
   logic [31:0] data_to_mem;
   logic        WE;
   logic [31:0] data_from_mem;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   int unsigned tests = 0;
   int unsigned fails = 0;

   data_mem_responder #(
      .MEM_WORDS (256),
      .FIFO_DEPTH(8),
      .IO_BASE   (32'h0000_8000)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .address_to_mem(address_to_mem),
      .data_to_mem   (data_to_mem),
      .WE            (WE),
      .data_from_mem (data_from_mem),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_ready     (out_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      address_to_mem = a;
      data_to_mem    = d;
      WE             = 1'b1;
      @(posedge clk);
      #1;
      WE = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      WE             = 1'b0;
      address_to_mem = a;
      #1;
      d = data_from_mem;
   endtask

   logic [31:0] r;
   logic [31:0] q[$];
   logic [31:0] prev;
   logic        stalled;
   logic        rdy;
   logic        do_push;
   logic [31:0] word;
   int unsigned next_val;
   int unsigned delivered;

   initial begin
      reset          = 1'b1;
      WE             = 1'b0;
      out_ready      = 1'b0;
      address_to_mem = '0;
      data_to_mem    = '0;
      #2;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_data", out_data, 32'h0);
      rd(STATUS, r); check("rst_status", r, 32'h1);
      rd(CYCLE, r);  check("rst_cycle", r, 32'h0);
      rd(DROPS, r);  check("rst_drops", r, 32'h0);

      // Cycle counter: five edges after release, then load near wrap.
      @(negedge clk);
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rd(CYCLE, r); check("cycle_edge5", r, 32'd5);
      wr(CYCLE, 32'hFFFF_FFFE);
      rd(CYCLE, r); check("cycle_load", r, 32'hFFFF_FFFE);
      @(posedge clk); #1;
      rd(CYCLE, r); check("cycle_max", r, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      rd(CYCLE, r); check("cycle_wrap", r, 32'h0);

      // RAM and unmapped gap.
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, r);  check("ram_10", r, 32'hDEAD_BEEF);
      rd(32'h13, r);  check("ram_13", r, 32'hDEAD_BEEF);
      rd(32'h400, r); check("gap_400", r, 32'h0);
      wr(32'h400, 32'h1234_5678);
      rd(32'h400, r); check("gap_wr_ignored", r, 32'h0);
      rd(TXDATA, r);  check("txdata_read0", r, 32'h0);

      // FIFO fill, overflow drop, then push accepted alongside a pop.
      for (int i = 1; i <= 8; i++) wr(TXDATA, 32'(i));
      rd(STATUS, r); check("status_full", r, 32'h0802);
      check("head_1", out_data, 32'd1);
      wr(TXDATA, 32'd9);
      rd(DROPS, r);  check("drops_1", r, 32'd1);
      rd(STATUS, r); check("status_after_drop", r, 32'h0802);
      check("head_after_drop", out_data, 32'd1);
      @(negedge clk);
      address_to_mem = TXDATA; data_to_mem = 32'd10; WE = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      WE = 1'b0; out_ready = 1'b0;
      rd(STATUS, r); check("status_push_pop_full", r, 32'h0802);
      rd(DROPS, r);  check("drops_still_1", r, 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("drain_valid", 32'(out_valid), 32'h1);
         check("drain_data", out_data, (i == 7) ? 32'd10 : 32'(i + 2));
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
      rd(STATUS, r); check("status_empty", r, 32'h1);
      check("empty_data", out_data, 32'h0);
      wr(DROPS, 32'hFFFF_FFFF);
      rd(DROPS, r);  check("drops_clear", r, 32'h0);

      // Push with ready high while empty: push only.
      @(negedge clk);
      address_to_mem = TXDATA; data_to_mem = 32'h55; WE = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      WE = 1'b0; out_ready = 1'b0;
      rd(STATUS, r); check("status_one", r, 32'h0100);
      check("one_data", out_data, 32'h55);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1; out_ready = 1'b0;

      // Async reset mid-stream.
      for (int i = 0; i < 3; i++) wr(TXDATA, 32'hC0 + 32'(i));
      rd(STATUS, r); check("status_three", r, 32'h0300);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_data", out_data, 32'h0);
      rd(STATUS, r); check("midrst_status", r, 32'h1);
      rd(32'h10, r); check("midrst_ram", r, 32'hDEAD_BEEF);
      @(negedge clk);
      reset = 1'b0;

      // Backpressure: 100 words, random ready, never overflowing.
      next_val  = 1;
      delivered = 0;
      stalled   = 1'b0;
      prev      = '0;
      for (int cyc = 0; cyc < 2000 && delivered < 100; cyc++) begin
         @(negedge clk);
         check("bp_valid", 32'(out_valid), 32'(q.size() != 0));
         if (q.size() != 0) check("bp_data", out_data, q[0]);
         if (stalled) check("bp_stable", out_data, prev);
         rdy     = 1'($urandom_range(0, 1));
         do_push = (next_val <= 100) && (q.size() < 8);
         word    = 32'hA000_0000 + 32'(next_val);
         out_ready      = rdy;
         WE             = do_push;
         address_to_mem = TXDATA;
         data_to_mem    = word;
         stalled = out_valid && !rdy;
         prev    = out_data;
         @(posedge clk); #1;
         if (rdy && q.size() != 0) begin
            void'(q.pop_front());
            delivered++;
         end
         if (do_push) begin
            q.push_back(word);
            next_val++;
         end
      end
      WE = 1'b0;
      out_ready = 1'b0;
      check("bp_delivered", 32'(delivered), 32'd100);
      rd(DROPS, r); check("bp_no_drops", r, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
